inv_diffusion_seq: RTL and testbench

Sequential inverse diffusion unit for the AES decryption datapath: applies InvShiftRows followed by InvMixColumns to a 4x4 byte state. It is the decrypt-side counterpart of the combinational `diffusion` block. It sits between the inverse S-box stage and the round-key XOR. Mixing is iterative, one column per clock, behind a valid/ready handshake, with a bypass for the decryption round that omits InvMixColumns.

---
 rtl/aes_pkg.sv | 58 +++++
 rtl/inv_mix_column.sv | 14 +
 rtl/inv_diffusion_seq.sv | 89 ++++++++
 tb/tb_inv_diffusion_seq.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES types and GF(2^8) helpers for the decrypt-side diffusion blocks.
// State layout is [row][col][bit].
package aes_pkg;

  typedef logic [3:0][3:0][7:0] aes_state_t;
  typedef logic [3:0][7:0]      aes_col_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PROC = 2'd1,
    ST_DONE = 2'd2
  } fsm_state_t;

  // Multiply by x, reduce by x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul09(input logic [7:0] b);
    logic [7:0] x8;
    x8 = xtime(xtime(xtime(b)));
    return x8 ^ b;
  endfunction

  function automatic logic [7:0] gmul0b(input logic [7:0] b);
    logic [7:0] x2, x8;
    x2 = xtime(b);
    x8 = xtime(xtime(x2));
    return x8 ^ x2 ^ b;
  endfunction

  function automatic logic [7:0] gmul0d(input logic [7:0] b);
    logic [7:0] x4, x8;
    x4 = xtime(xtime(b));
    x8 = xtime(x4);
    return x8 ^ x4 ^ b;
  endfunction

  function automatic logic [7:0] gmul0e(input logic [7:0] b);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x4 ^ x2;
  endfunction

  // Row r rotates right by r: out[r][c] = in[r][(c - r) mod 4].
  function automatic aes_state_t inv_shift_rows(input aes_state_t s);
    aes_state_t o;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        o[r][c] = s[r][2'(c - r)];
      end
    end
    return o;
  endfunction

endpackage

// File: rtl/inv_mix_column.sv
// Combinational InvMixColumn on one column; byte 0 is row 0.
module inv_mix_column
  import aes_pkg::*;
(
  input  aes_col_t col_i,
  output aes_col_t col_o
);

  assign col_o[0] = gmul0e(col_i[0]) ^ gmul0b(col_i[1]) ^ gmul0d(col_i[2]) ^ gmul09(col_i[3]);
  assign col_o[1] = gmul09(col_i[0]) ^ gmul0e(col_i[1]) ^ gmul0b(col_i[2]) ^ gmul0d(col_i[3]);
  assign col_o[2] = gmul0d(col_i[0]) ^ gmul09(col_i[1]) ^ gmul0e(col_i[2]) ^ gmul0b(col_i[3]);
  assign col_o[3] = gmul0b(col_i[0]) ^ gmul0d(col_i[1]) ^ gmul09(col_i[2]) ^ gmul0e(col_i[3]);

endmodule

// File: rtl/inv_diffusion_seq.sv
// Iterative InvShiftRows + InvMixColumns, one column per clock, with a
// skip path for the final decrypt round. Single shared column mixer.
module inv_diffusion_seq
  import aes_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       skip_mix,
  input  aes_state_t diffusion_in,
  output logic       out_valid,
  input  logic       out_ready,
  output aes_state_t diffusion_out,
  output aes_state_t isrows_out,
  output logic       busy
);

  fsm_state_t state_q, state_d;
  logic [1:0] col_idx_q;
  logic       skip_q;
  aes_state_t work_q, work_mixed, isr_in, dout_q, isrows_q;
  aes_col_t   mix_in, mix_out;
  logic       accept;

  assign isr_in = inv_shift_rows(diffusion_in);
  assign accept = (state_q == ST_IDLE) && in_valid;

  always_comb begin
    mix_in = '0;
    for (int r = 0; r < 4; r++) mix_in[r] = work_q[r][col_idx_q];
  end

  inv_mix_column u_imc (
    .col_i(mix_in),
    .col_o(mix_out)
  );

  always_comb begin
    work_mixed = work_q;
    for (int r = 0; r < 4; r++) work_mixed[r][col_idx_q] = mix_out[r];
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (in_valid) state_d = skip_mix ? ST_DONE : ST_PROC;
      ST_PROC: if (col_idx_q == 2'd3 || skip_q) state_d = ST_DONE;
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    out_valid = (state_q == ST_DONE);
    busy      = (state_q == ST_PROC) || (state_q == ST_DONE);
  end

  // col_idx holds at 3 after the last column; it only rewinds on capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      work_q    <= '0;
      isrows_q  <= '0;
      dout_q    <= '0;
      col_idx_q <= '0;
      skip_q    <= 1'b0;
    end else if (accept) begin
      work_q    <= isr_in;
      isrows_q  <= isr_in;
      col_idx_q <= '0;
      skip_q    <= skip_mix;
      if (skip_mix) dout_q <= isr_in;
    end else if (state_q == ST_PROC) begin
      work_q <= work_mixed;
      if (col_idx_q == 2'd3) dout_q    <= work_mixed;
      else                   col_idx_q <= col_idx_q + 2'd1;
    end
  end

  assign diffusion_out = dout_q;
  assign isrows_out    = isrows_q;

endmodule

// File: tb/tb_inv_diffusion_seq.sv
// Directed and random checks of inv_diffusion_seq against a GF(2^8)
// polynomial-arithmetic reference of InvShiftRows / InvMixColumns.
module tb_inv_diffusion_seq;

  typedef logic [3:0][3:0][7:0] st_t;

  logic clk = 1'b0;
  logic reset, in_valid, skip_mix, out_ready;
  logic in_ready, out_valid, busy;
  st_t  din, dout, isrows;

  int errors = 0;
  int checks = 0;

  inv_diffusion_seq dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .skip_mix(skip_mix),
    .diffusion_in(din),
    .out_valid(out_valid), .out_ready(out_ready),
    .diffusion_out(dout), .isrows_out(isrows), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Schoolbook polynomial product then long division by 0x11B.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
    return p[7:0];
  endfunction

  function automatic st_t m_isr(input st_t s);
    st_t o;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[r][c] = s[r][(c - r + 4) % 4];
    return o;
  endfunction

  function automatic st_t m_imc(input st_t s);
    logic [7:0] m [4][4];
    st_t o;
    m = '{'{8'h0e, 8'h0b, 8'h0d, 8'h09},
          '{8'h09, 8'h0e, 8'h0b, 8'h0d},
          '{8'h0d, 8'h09, 8'h0e, 8'h0b},
          '{8'h0b, 8'h0d, 8'h09, 8'h0e}};
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        o[r][c] = 8'h00;
        for (int k = 0; k < 4; k++) o[r][c] = o[r][c] ^ gf_mul(m[r][k], s[k][c]);
      end
    return o;
  endfunction

  function automatic st_t rnd_state();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One full transaction: accept, bounded wait for result, release.
  task automatic run(input st_t s, input logic sk, input string tag);
    st_t exp_isr, exp_out;
    int n;
    exp_isr = m_isr(s);
    exp_out = sk ? exp_isr : m_imc(exp_isr);
    in_valid = 1'b1; skip_mix = sk; din = s;
    @(posedge clk); #1;
    in_valid = 1'b0; skip_mix = ~sk; din = rnd_state();
    chk({tag, "_isrows"}, 128'(isrows), 128'(exp_isr));
    n = 0;
    while (!out_valid && n < 12) begin
      @(posedge clk); #1; n++;
    end
    chk({tag, "_latency"}, 128'(n), sk ? 128'd0 : 128'd4);
    chk({tag, "_out"}, 128'(dout), 128'(exp_out));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_release"}, 128'({out_valid, in_ready, busy}), 128'(3'b010));
    chk({tag, "_hold"}, 128'(dout), 128'(exp_out));
  endtask

  initial begin
    st_t s, e, keep;
    logic [7:0] vc [4][4];
    logic [7:0] ec [4][4];
    logic [7:0] es [4][4];
    logic [7:0] col [4];
    logic [7:0] rowv [4];
    logic ok;
    int n;

    reset = 1'b1; in_valid = 1'b0; skip_mix = 1'b0; out_ready = 1'b0; din = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_in_ready", 128'(in_ready), 128'd1);
    chk("reset_out_valid", 128'(out_valid), 128'd0);
    chk("reset_busy", 128'(busy), 128'd0);
    chk("reset_dout", 128'(dout), 128'd0);
    chk("reset_isrows", 128'(isrows), 128'd0);

    // Every column {8e,4d,a1,bc}: InvMixColumn gives {db,13,53,45}.
    col = '{8'h8e, 8'h4d, 8'ha1, 8'hbc};
    rowv = '{8'hdb, 8'h13, 8'h53, 8'h45};
    for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) s[r][c] = col[r];
    run(s, 1'b0, "fips_col");
    for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) e[r][c] = rowv[r];
    chk("fips_col_const", 128'(dout), 128'(e));

    // Per-column vectors placed so they land in column c after InvShiftRows.
    vc = '{'{8'h9f, 8'hdc, 8'h58, 8'h9d}, '{8'hd5, 8'hd5, 8'hd7, 8'hd6},
           '{8'hc6, 8'hc6, 8'hc6, 8'hc6}, '{8'h01, 8'h01, 8'h01, 8'h01}};
    ec = '{'{8'hf2, 8'h0a, 8'h22, 8'h5c}, '{8'hd4, 8'hd4, 8'hd4, 8'hd5},
           '{8'hc6, 8'hc6, 8'hc6, 8'hc6}, '{8'h01, 8'h01, 8'h01, 8'h01}};
    for (int r = 0; r < 4; r++)
      for (int k = 0; k < 4; k++) s[r][k] = vc[(k + r) % 4][r];
    run(s, 1'b0, "vec");
    for (int c = 0; c < 4; c++) begin
      logic [31:0] got, exp;
      for (int r = 0; r < 4; r++) begin
        got[r*8 +: 8] = dout[r][c];
        exp[r*8 +: 8] = ec[c][r];
      end
      chk($sformatf("vec_col%0d", c), 128'(got), 128'(exp));
    end

    // Skip path with rows {01,02,03,04}.
    for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) s[r][c] = 8'(c + 1);
    run(s, 1'b1, "skip");
    es = '{'{8'h01, 8'h02, 8'h03, 8'h04}, '{8'h04, 8'h01, 8'h02, 8'h03},
           '{8'h03, 8'h04, 8'h01, 8'h02}, '{8'h02, 8'h03, 8'h04, 8'h01}};
    for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) e[r][c] = es[r][c];
    chk("skip_const", 128'(dout), 128'(e));

    // out_ready held high early: out_valid lasts exactly one cycle.
    s = rnd_state();
    out_ready = 1'b1; in_valid = 1'b1; skip_mix = 1'b1; din = s;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("early_rdy_valid", 128'(out_valid), 128'd1);
    chk("early_rdy_out", 128'(dout), 128'(m_isr(s)));
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("early_rdy_drop", 128'({out_valid, in_ready}), 128'(2'b01));

    // Backpressure: result held 10 cycles while in_valid pulses are ignored.
    s = rnd_state();
    e = m_imc(m_isr(s));
    keep = m_isr(s);
    in_valid = 1'b1; skip_mix = 1'b0; din = s;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 12) begin @(posedge clk); #1; n++; end
    chk("bp_latency", 128'(n), 128'd4);
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0]; skip_mix = 1'b1; din = rnd_state();
      @(posedge clk); #1;
      if (!(out_valid === 1'b1 && in_ready === 1'b0 && dout === e)) ok = 1'b0;
    end
    in_valid = 1'b0;
    chk("bp_stable", 128'(ok), 128'd1);
    chk("bp_isrows_kept", 128'(isrows), 128'(keep));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_release", 128'({in_ready, out_valid}), 128'(2'b10));
    chk("bp_out_kept", 128'(dout), 128'(e));

    // Reset mid-PROC abandons the operation.
    s = rnd_state();
    in_valid = 1'b1; skip_mix = 1'b0; din = s;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("mid_busy", 128'(busy), 128'd1);
    reset = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    chk("mid_rst_ctrl", 128'({in_ready, out_valid, busy}), 128'(3'b100));
    chk("mid_rst_dout", 128'(dout), 128'd0);
    chk("mid_rst_isrows", 128'(isrows), 128'd0);
    ok = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) ok = 1'b0;
    end
    chk("mid_rst_no_valid", 128'(ok), 128'd1);
    run(rnd_state(), 1'b0, "post_rst");

    for (int i = 0; i < 20; i++)
      run(rnd_state(), 1'($urandom_range(0, 3) == 0), $sformatf("rnd%0d", i));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
